// File: rtl/dcache_miss_stall_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_miss_stall_ctrl
//
// Sequences data-cache miss handling for the MEM stage and owns the pipeline
// freeze. While a dirty-victim writeback and/or a line refill runs on the
// memory port, hold_o freezes the IF_ID/ID_EX/EX_MEM/MEM_WB registers. Also
// keeps saturating miss and stall-cycle performance counters.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous, active-high reset
//   mem_access_i   MEM stage holds a valid load/store this cycle
//   hit_i          cache tag hit for the current MEM access
//   dirty_i        victim line at the current index is valid+dirty
//   miss_addr_i    byte address of the current MEM access
//   victim_addr_i  address of the victim line (tag|index)
//   mem_ack_i      memory finished the current request (1-cycle pulse)
//   mem_req_o      memory request level, held until ack
//   mem_write_o    1 = victim writeback, 0 = refill read
//   mem_addr_o     line-aligned request address
//   cache_fill_o   1-cycle pulse: write returned line, clear dirty
//   hold_o         freeze all pipeline registers
//   miss_cnt_o     misses taken (saturating)
//   stall_cnt_o    cycles with hold_o = 1 (saturating)
// -----------------------------------------------------------------------------
module dcache_miss_stall_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 32,
   parameter int CNT_W      = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mem_access_i,
   input  logic              hit_i,
   input  logic              dirty_i,
   input  logic [ADDR_W-1:0] miss_addr_i,
   input  logic [ADDR_W-1:0] victim_addr_i,
   input  logic              mem_ack_i,
   output logic              mem_req_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              cache_fill_o,
   output logic              hold_o,
   output logic [CNT_W-1:0]  miss_cnt_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WB   = 2'd1,
      S_FILL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                fill_q, fill_d;
   logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic                miss;
   logic                hold;
   logic                ack;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
      return a & ~OFF_MASK;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // A miss is only recognised in IDLE; once the FSM is busy the pipeline is
   // frozen and the MEM-stage inputs are don't-care.
   assign miss = (state_q == S_IDLE) && mem_access_i && !hit_i;

   // Combinational so the pipeline freezes in the very cycle the miss is seen.
   // Gated by rst_i so the freeze drops as soon as reset is asserted.
   assign hold = !rst_i && ((state_q != S_IDLE) || miss);

   // Acks only count while a request is actually outstanding.
   assign ack = mem_ack_i && req_q;

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      write_d     = write_q;
      addr_d      = addr_q;
      fill_d      = 1'b0;
      miss_cnt_d  = miss_cnt_q;
      stall_cnt_d = hold ? sat_inc(stall_cnt_q) : stall_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (miss) begin
               miss_cnt_d = sat_inc(miss_cnt_q);
               req_d      = 1'b1;
               if (dirty_i) begin
                  state_d = S_WB;
                  write_d = 1'b1;
                  addr_d  = line_align(victim_addr_i);
               end else begin
                  state_d = S_FILL;
                  write_d = 1'b0;
                  addr_d  = line_align(miss_addr_i);
               end
            end
         end
         S_WB: begin
            // Switch straight to the refill read; req stays high so the port
            // never sees an idle cycle between writeback and refill.
            if (ack) begin
               state_d = S_FILL;
               write_d = 1'b0;
               addr_d  = line_align(miss_addr_i);
            end
         end
         S_FILL: begin
            if (ack) begin
               state_d = S_DONE;
               req_d   = 1'b0;
               fill_d  = 1'b1;
            end
         end
         S_DONE: begin
            // Cache retries the lookup this cycle and hits; release next cycle.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         fill_q      <= 1'b0;
         miss_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         fill_q      <= fill_d;
         miss_cnt_q  <= miss_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mem_req_o    = req_q;
   assign mem_write_o  = write_q;
   assign mem_addr_o   = addr_q;
   assign cache_fill_o = fill_q;
   assign hold_o       = hold;
   assign miss_cnt_o   = miss_cnt_q;
   assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_dcache_miss_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_miss_stall_ctrl
//
// Directed bench for dcache_miss_stall_ctrl (built with CNT_W = 4 so counter
// saturation is reachable). Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dcache_miss_stall_ctrl;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 4;

   logic              clk_i;
   logic              rst_i;
   logic              mem_access_i;
   logic              hit_i;
   logic              dirty_i;
   logic [ADDR_W-1:0] miss_addr_i;
   logic [ADDR_W-1:0] victim_addr_i;
   logic              mem_ack_i;
   logic              mem_req_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              cache_fill_o;
   logic              hold_o;
   logic [CNT_W-1:0]  miss_cnt_o;
   logic [CNT_W-1:0]  stall_cnt_o;

   int n_total = 0;
   int n_pass  = 0;

   dcache_miss_stall_ctrl #(
      .ADDR_W     (ADDR_W),
      .LINE_BYTES (32),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .mem_access_i  (mem_access_i),
      .hit_i         (hit_i),
      .dirty_i       (dirty_i),
      .miss_addr_i   (miss_addr_i),
      .victim_addr_i (victim_addr_i),
      .mem_ack_i     (mem_ack_i),
      .mem_req_o     (mem_req_o),
      .mem_write_o   (mem_write_o),
      .mem_addr_o    (mem_addr_o),
      .cache_fill_o  (cache_fill_o),
      .hold_o        (hold_o),
      .miss_cnt_o    (miss_cnt_o),
      .stall_cnt_o   (stall_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        acc;
      logic        hit;
      logic        dirty;
      logic        ack;
      logic [31:0] maddr;
      logic [31:0] vaddr;
      logic        e_req;
      logic        e_wr;
      logic [31:0] e_addr;
      logic        e_fill;
      logic        e_hold;
      int          e_miss;
      int          e_stall;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
   endtask

   task automatic add(input logic acc, input logic hit, input logic dirty, input logic ack,
                      input logic [31:0] maddr, input logic [31:0] vaddr,
                      input logic e_req, input logic e_wr, input logic [31:0] e_addr,
                      input logic e_fill, input logic e_hold, input int e_miss, input int e_stall);
      vec_t v;
      v.acc = acc; v.hit = hit; v.dirty = dirty; v.ack = ack;
      v.maddr = maddr; v.vaddr = vaddr;
      v.e_req = e_req; v.e_wr = e_wr; v.e_addr = e_addr;
      v.e_fill = e_fill; v.e_hold = e_hold; v.e_miss = e_miss; v.e_stall = e_stall;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic acc, input logic hit, input logic dirty, input logic ack,
                        input logic [31:0] maddr, input logic [31:0] vaddr);
      mem_access_i  = acc;
      hit_i         = hit;
      dirty_i       = dirty;
      mem_ack_i     = ack;
      miss_addr_i   = maddr;
      victim_addr_i = vaddr;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      // Miss-looking inputs during reset: hold_o must still be low.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_5555, 32'h0000_6666);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst.hold",  32'(hold_o),       32'h0);
      chk("rst.req",   32'(mem_req_o),    32'h0);
      chk("rst.write", 32'(mem_write_o),  32'h0);
      chk("rst.addr",  mem_addr_o,        32'h0);
      chk("rst.fill",  32'(cache_fill_o), 32'h0);
      chk("rst.miss",  32'(miss_cnt_o),   32'h0);
      chk("rst.stall", 32'(stall_cnt_o),  32'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // ---- hits only: no stall, no request ----
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0);
         @(negedge clk_i);
         chk($sformatf("hit%0d.hold", i), 32'(hold_o),    32'h0);
         chk($sformatf("hit%0d.req", i),  32'(mem_req_o), 32'h0);
         @(posedge clk_i);
         #1;
      end
      chk("hit.miss",  32'(miss_cnt_o),  32'h0);
      chk("hit.stall", 32'(stall_cnt_o), 32'h0);

      // ---- table: clean miss, dirty miss, spurious acks ----
      //   acc hit dty ack maddr         vaddr         req wr addr          fill hold miss stall
      // clean miss 0x1234, ack on 3rd request cycle
      add(1, 0, 0, 0, 32'h0000_1234, 32'h0,         0, 0, 32'h0000_0000, 0, 1, 0, 0);
      add(1, 0, 0, 0, 32'h0000_1234, 32'h0,         1, 0, 32'h0000_1220, 0, 1, 1, 1);
      add(1, 0, 0, 0, 32'h0000_1234, 32'h0,         1, 0, 32'h0000_1220, 0, 1, 1, 2);
      add(1, 0, 0, 1, 32'h0000_1234, 32'h0,         1, 0, 32'h0000_1220, 0, 1, 1, 3);
      add(1, 1, 0, 0, 32'h0000_1234, 32'h0,         0, 0, 32'h0000_1220, 1, 1, 1, 4);
      add(1, 1, 0, 0, 32'h0000_1234, 32'h0,         0, 0, 32'h0000_1220, 0, 0, 1, 5);
      // dirty miss: writeback 0x8040 then refill 0x1000, req held across
      add(1, 0, 1, 0, 32'h0000_1004, 32'h0000_8040, 0, 0, 32'h0000_1220, 0, 1, 1, 5);
      add(1, 0, 1, 0, 32'h0000_1004, 32'h0000_8040, 1, 1, 32'h0000_8040, 0, 1, 2, 6);
      add(1, 0, 1, 1, 32'h0000_1004, 32'h0000_8040, 1, 1, 32'h0000_8040, 0, 1, 2, 7);
      add(1, 0, 1, 0, 32'h0000_1004, 32'h0000_8040, 1, 0, 32'h0000_1000, 0, 1, 2, 8);
      add(1, 0, 1, 1, 32'h0000_1004, 32'h0000_8040, 1, 0, 32'h0000_1000, 0, 1, 2, 9);
      add(1, 1, 0, 0, 32'h0000_1004, 32'h0000_8040, 0, 0, 32'h0000_1000, 1, 1, 2, 10);
      add(1, 1, 0, 0, 32'h0000_1004, 32'h0000_8040, 0, 0, 32'h0000_1000, 0, 0, 2, 11);
      // spurious acks in IDLE (with and without miss) and in DONE
      add(1, 1, 0, 1, 32'h0000_1004, 32'h0,         0, 0, 32'h0000_1000, 0, 0, 2, 11);
      add(1, 0, 0, 1, 32'h0000_2000, 32'h0,         0, 0, 32'h0000_1000, 0, 1, 2, 11);
      add(1, 0, 0, 1, 32'h0000_2000, 32'h0,         1, 0, 32'h0000_2000, 0, 1, 3, 12);
      add(1, 1, 0, 1, 32'h0000_2000, 32'h0,         0, 0, 32'h0000_2000, 1, 1, 3, 13);
      add(1, 1, 0, 1, 32'h0000_2000, 32'h0,         0, 0, 32'h0000_2000, 0, 0, 3, 14);
      add(0, 0, 0, 0, 32'h0000_2000, 32'h0,         0, 0, 32'h0000_2000, 0, 0, 3, 14);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].acc, vecs[i].hit, vecs[i].dirty, vecs[i].ack, vecs[i].maddr, vecs[i].vaddr);
         @(negedge clk_i);
         chk($sformatf("row%0d.req", i),   32'(mem_req_o),    32'(vecs[i].e_req));
         chk($sformatf("row%0d.write", i), 32'(mem_write_o),  32'(vecs[i].e_wr));
         chk($sformatf("row%0d.addr", i),  mem_addr_o,        vecs[i].e_addr);
         chk($sformatf("row%0d.fill", i),  32'(cache_fill_o), 32'(vecs[i].e_fill));
         chk($sformatf("row%0d.hold", i),  32'(hold_o),       32'(vecs[i].e_hold));
         chk($sformatf("row%0d.miss", i),  32'(miss_cnt_o),   32'(vecs[i].e_miss));
         chk($sformatf("row%0d.stall", i), 32'(stall_cnt_o),  32'(vecs[i].e_stall));
         @(posedge clk_i);
         #1;
      end

      // ---- async reset during FILL ----
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3004, 32'h0);
      @(posedge clk_i);
      #1;
      chk("arst.pre_req",  32'(mem_req_o), 32'h1);
      chk("arst.pre_addr", mem_addr_o,     32'h0000_3000);
      #2;
      rst_i = 1'b1;
      #1;
      chk("arst.req",   32'(mem_req_o),    32'h0);
      chk("arst.hold",  32'(hold_o),       32'h0);
      chk("arst.addr",  mem_addr_o,        32'h0);
      chk("arst.miss",  32'(miss_cnt_o),   32'h0);
      chk("arst.stall", 32'(stall_cnt_o),  32'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3004, 32'h0);
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      @(negedge clk_i);
      chk("arst.late_fill", 32'(cache_fill_o), 32'h0);
      chk("arst.late_req",  32'(mem_req_o),    32'h0);
      chk("arst.late_hold", 32'(hold_o),       32'h0);
      @(posedge clk_i);
      #1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3004, 32'h0);
      @(negedge clk_i);
      chk("arst.idle_hold",  32'(hold_o),       32'h0);
      chk("arst.idle_fill",  32'(cache_fill_o), 32'h0);
      chk("arst.idle_stall", 32'(stall_cnt_o),  32'h0);
      @(posedge clk_i);
      #1;

      // ---- counter saturation: back-to-back clean misses, 3 cycles each ----
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 32'h0);
      repeat (15) @(posedge clk_i);
      #1;
      chk("sat.miss5",   32'(miss_cnt_o),  32'd5);
      chk("sat.stall15", 32'(stall_cnt_o), 32'd15);
      repeat (33) @(posedge clk_i);
      #1;
      chk("sat.miss",  32'(miss_cnt_o),  32'd15);
      chk("sat.stall", 32'(stall_cnt_o), 32'd15);
      chk("sat.hold",  32'(hold_o),      32'h1);
      chk("sat.req",   32'(mem_req_o),   32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk_i);
      #1;
      chk("sat.end_hold", 32'(hold_o),     32'h0);
      chk("sat.end_miss", 32'(miss_cnt_o), 32'd15);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
